contour_scheduler: RTL and testbench

//   Sequences the contour tracer over a queue of seed addresses and shares its

---
 rtl/contour_pkg.sv | 19 +
 rtl/seed_fifo.sv | 50 +++++
 rtl/contour_scheduler.sv | 159 +++++++++++++++
 tb/tb_contour_scheduler.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/contour_pkg.sv
// Shared definitions for the contour scheduler: scheduler FSM states, tracer
// state codes and frame geometry.
package contour_pkg;

  localparam int unsigned FRAME_W = 640;
  localparam int unsigned ADDR_W  = 19;

  localparam logic [2:0] ST_DONE = 3'd5;
  localparam logic [2:0] ST_FAKE = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CLEAR,
    S_RUN,
    S_RESULT
  } sched_state_t;

endpackage

// File: rtl/seed_fifo.sv
// Synchronous seed FIFO with show-ahead head output and occupancy count.
module seed_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 19
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/contour_scheduler.sv
// Runs the contour tracer over queued seeds and arbitrates the shared BRAM port
// between the tracer and the frame readout.
module contour_scheduler
  import contour_pkg::*;
#(
  parameter int unsigned SEED_DEPTH  = 8,
  parameter int unsigned ADDR_W      = contour_pkg::ADDR_W,
  parameter int unsigned TIMEOUT_CYC = 1048576,
  parameter logic [2:0]  ST_DONE     = contour_pkg::ST_DONE,
  parameter logic [2:0]  ST_FAKE     = contour_pkg::ST_FAKE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] seed_addr,
  input  logic              seed_valid,
  output logic              seed_ready,
  input  logic              go,
  output logic              busy,
  output logic              all_done,
  output logic              tr_reset,
  output logic              tr_start,
  output logic [ADDR_W-1:0] tr_addr_start,
  input  logic              tr_done,
  input  logic [2:0]        tr_state,
  input  logic [ADDR_W-1:0] tr_addr,
  input  logic              tr_we,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_grant,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic              res_valid,
  output logic              res_closed,
  output logic              res_timeout,
  output logic [7:0]        res_idx
);
  localparam int unsigned CNT_W = $clog2(SEED_DEPTH) + 1;

  sched_state_t      state;
  sched_state_t      next_state;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [ADDR_W-1:0] fifo_head;
  logic              clr_phase;
  logic [20:0]       tmo_cnt;
  logic              tmo_hit;
  logic              tracer_owns;

  assign seed_ready = !fifo_full && !reset;
  assign tmo_hit    = (tmo_cnt == 21'(TIMEOUT_CYC - 1));

  seed_fifo #(
    .DEPTH(SEED_DEPTH),
    .WIDTH(ADDR_W)
  ) u_seed_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (seed_valid && seed_ready),
    .push_data(seed_addr),
    .pop      (state == S_LOAD),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  always_comb begin
    next_state  = state;
    tr_reset    = 1'b1;
    tr_start    = 1'b0;
    tracer_owns = 1'b0;
    case (state)
      S_IDLE:   if (go && !fifo_empty) next_state = S_LOAD;
      S_LOAD:   next_state = S_CLEAR;
      S_CLEAR: begin
        tracer_owns = 1'b1;
        if (clr_phase) next_state = S_RUN;
      end
      S_RUN: begin
        tr_reset    = 1'b0;
        tr_start    = 1'b1;
        tracer_owns = 1'b1;
        if (tr_done || tmo_hit) next_state = S_RESULT;
      end
      S_RESULT: next_state = (fifo_count != '0) ? S_LOAD : S_IDLE;
      default:  next_state = S_IDLE;
    endcase
    // Tracer writes are only honoured while it actually runs; CLEAR owns the port write-masked.
    mem_addr = tracer_owns ? tr_addr : rd_addr;
    mem_we   = (state == S_RUN) && tr_we;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      clr_phase     <= 1'b0;
      tmo_cnt       <= '0;
      busy          <= 1'b0;
      all_done      <= 1'b0;
      tr_addr_start <= '0;
      rd_grant      <= 1'b0;
      res_valid     <= 1'b0;
      res_closed    <= 1'b0;
      res_timeout   <= 1'b0;
      res_idx       <= '0;
    end else begin
      state     <= next_state;
      all_done  <= 1'b0;
      res_valid <= 1'b0;
      // Grant computed from the upcoming state so it drops on the first CLEAR cycle.
      rd_grant  <= rd_req && !(next_state == S_CLEAR || next_state == S_RUN);
      case (state)
        S_IDLE: begin
          if (go) begin
            if (fifo_empty) begin
              all_done <= 1'b1;
            end else begin
              busy    <= 1'b1;
              res_idx <= '0;
            end
          end
        end
        S_LOAD: tr_addr_start <= fifo_head;
        S_CLEAR: begin
          clr_phase <= ~clr_phase;
          tmo_cnt   <= '0;
        end
        S_RUN: begin
          if (tmo_cnt != '1) tmo_cnt <= tmo_cnt + 21'd1;
          if (tr_done) begin
            res_valid   <= 1'b1;
            res_closed  <= (tr_state == ST_DONE);
            res_timeout <= 1'b0;
          end else if (tmo_hit) begin
            res_valid   <= 1'b1;
            res_closed  <= 1'b0;
            res_timeout <= 1'b1;
          end
        end
        S_RESULT: begin
          res_idx <= res_idx + 8'd1;
          if (fifo_count == '0) begin
            all_done <= 1'b1;
            busy     <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // A done flag outside the two terminal codes means the tracer's state codes disagree with ours.
  always_ff @(posedge clk) begin
    if (!reset && state == S_RUN && tr_done)
      assert (tr_state == ST_DONE || tr_state == ST_FAKE);
  end

endmodule

// File: tb/tb_contour_scheduler.sv
// Randomised scoreboard bench for contour_scheduler with a behavioural tracer
// responder and a result/arbiter monitor.
`timescale 1ns/1ps
module tb_contour_scheduler;
  localparam int unsigned AW  = 19;
  localparam int unsigned TMO = 64;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] seed_addr = '0;
  logic          seed_valid = 1'b0;
  logic          seed_ready;
  logic          go = 1'b0;
  logic          busy, all_done, tr_reset, tr_start;
  logic [AW-1:0] tr_addr_start;
  logic          tr_done = 1'b0;
  logic [2:0]    tr_state = 3'd0;
  logic [AW-1:0] tr_addr = '0;
  logic          tr_we = 1'b0;
  logic          rd_req = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          rd_grant;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic          res_valid, res_closed, res_timeout;
  logic [7:0]    res_idx;

  contour_scheduler #(
    .SEED_DEPTH (8),
    .ADDR_W     (AW),
    .TIMEOUT_CYC(TMO),
    .ST_DONE    (3'd5),
    .ST_FAKE    (3'd6)
  ) dut (
    .clk(clk), .reset(reset), .seed_addr(seed_addr), .seed_valid(seed_valid),
    .seed_ready(seed_ready), .go(go), .busy(busy), .all_done(all_done),
    .tr_reset(tr_reset), .tr_start(tr_start), .tr_addr_start(tr_addr_start),
    .tr_done(tr_done), .tr_state(tr_state), .tr_addr(tr_addr), .tr_we(tr_we),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_grant(rd_grant), .mem_addr(mem_addr),
    .mem_we(mem_we), .res_valid(res_valid), .res_closed(res_closed),
    .res_timeout(res_timeout), .res_idx(res_idx)
  );

  always #5 clk = ~clk;

  typedef struct { logic [AW-1:0] addr; int dur; logic [2:0] fin; bit never; } plan_t;
  typedef struct { bit closed; bit timeout; logic [7:0] idx; int lat; } res_t;

  plan_t      pend[$];
  plan_t      run_q[$];
  res_t       exp_q[$];
  int         exp_all_done = 0;
  bit         model_busy = 1'b0;
  logic [7:0] model_idx = '0;
  int         checks = 0;
  int         passed = 0;
  int         cyc = 0;
  int         run_start = 0;
  bit         rd_hold = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Outcome of one trace: done by cycle TMO wins, otherwise the abort fires at TMO.
  function automatic res_t expect_of(input plan_t p, input logic [7:0] idx);
    res_t r;
    r.idx = idx;
    if (p.never || p.dur > int'(TMO)) begin
      r.closed = 1'b0; r.timeout = 1'b1; r.lat = int'(TMO);
    end else begin
      r.closed = (p.fin == 3'd5); r.timeout = 1'b0; r.lat = p.dur;
    end
    return r;
  endfunction

  // Tracer responder: runs the plan of the seed it was handed.
  initial begin : tracer
    plan_t      cur;
    int         run_cnt;
    bit         prev_start;
    int         gap;
    logic [1:0] g_hist;
    cur.addr = '0; cur.dur = 0; cur.fin = 3'd0; cur.never = 1'b1;
    run_cnt = 0; prev_start = 1'b0; gap = -1; g_hist = '0;
    forever begin
      @(negedge clk);
      tr_addr = AW'($urandom);
      tr_we   = 1'($urandom);
      if (reset) begin
        gap = -1;
      end else if (tr_start && !prev_start) begin
        chk("seed_available", run_q.size() != 0, 1);
        if (run_q.size() != 0) begin
          cur = run_q.pop_front();
          chk("tr_addr_start", tr_addr_start, cur.addr);
        end
        run_start = cyc;
        run_cnt   = 0;
        if (gap >= 0) chk("result_to_run_gap", gap, 3);
        if (rd_hold) chk("grant_low_in_clear", g_hist, 2'b00);
        gap = -1;
      end
      if (tr_start && !reset) begin
        run_cnt++;
        if (!cur.never && run_cnt >= cur.dur) begin tr_done = 1'b1; tr_state = cur.fin; end
        else begin tr_done = 1'b0; tr_state = 3'd2; end
      end else begin
        run_cnt = 0; tr_done = 1'b0; tr_state = 3'd0;
      end
      if (res_valid) gap = 0;
      else if (all_done) gap = -1;
      else if (gap >= 0 && !tr_start) gap++;
      g_hist     = {g_hist[0], rd_grant};
      prev_start = tr_start;
    end
  end

  // Monitor: scoreboard pops on res_valid / all_done, arbiter rules every cycle.
  initial begin : monitor
    res_t e;
    forever begin
      @(negedge clk);
      #1;
      if (!reset) begin
        if (tr_start) begin
          chk("mem_addr_tracer", mem_addr, tr_addr);
          chk("mem_we_tracer", mem_we, tr_we);
          chk("grant_low_in_run", rd_grant, 0);
        end else begin
          chk("mem_we_masked", mem_we, 0);
          if (rd_grant) chk("mem_addr_readout", mem_addr, rd_addr);
        end
        if (res_valid) begin
          chk("result_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("res_idx", res_idx, e.idx);
            chk("res_closed", res_closed, e.closed);
            chk("res_timeout", res_timeout, e.timeout);
            chk("res_latency", cyc - run_start, e.lat);
            if (rd_hold) begin
              chk("grant_in_result", rd_grant, 1);
              chk("mem_addr_in_result", mem_addr, rd_addr);
              chk("mem_we_in_result", mem_we, 0);
            end
          end
        end
        if (all_done) begin
          chk("all_done_expected", exp_all_done > 0, 1);
          if (exp_all_done > 0) exp_all_done--;
          chk("busy_at_all_done", busy, 0);
          chk("results_before_all_done", exp_q.size(), 0);
        end
      end
    end
  end

  task automatic push_seed(input logic [AW-1:0] a, input int dur, input logic [2:0] fin, input bit never);
    plan_t p;
    bit    exp_rdy;
    p.addr = a; p.dur = dur; p.fin = fin; p.never = never;
    @(negedge clk);
    seed_addr  = a;
    seed_valid = 1'b1;
    exp_rdy    = model_busy ? 1'b1 : (pend.size() < 8);
    #1;
    chk("seed_ready", seed_ready, exp_rdy);
    @(negedge clk);
    seed_valid = 1'b0;
    if (exp_rdy) begin
      run_q.push_back(p);
      if (model_busy) begin exp_q.push_back(expect_of(p, model_idx)); model_idx++; end
      else pend.push_back(p);
    end
  endtask

  task automatic do_go();
    bit was_empty;
    bit was_busy;
    @(negedge clk);
    go        = 1'b1;
    was_busy  = model_busy;
    was_empty = (pend.size() == 0);
    if (!was_busy) begin
      exp_all_done++;
      if (!was_empty) begin
        model_busy = 1'b1;
        model_idx  = '0;
        foreach (pend[i]) begin exp_q.push_back(expect_of(pend[i], model_idx)); model_idx++; end
        pend.delete();
      end
    end
    @(negedge clk);
    go = 1'b0;
    #1;
    if (!was_busy && was_empty) begin
      chk("empty_go_all_done", all_done, 1);
      chk("empty_go_busy", busy, 0);
      chk("empty_go_tr_start", tr_start, 0);
      @(negedge clk); #1;
      chk("empty_go_single_pulse", all_done, 0);
      chk("empty_go_busy_later", busy, 0);
      chk("empty_go_tr_start_later", tr_start, 0);
    end else begin
      chk("busy_after_go", busy, 1);
    end
  endtask

  task automatic wait_drain(input int budget, input bit rand_rd);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || exp_all_done != 0) && n < budget) begin
      @(negedge clk);
      if (rand_rd) begin
        if (rd_grant || !rd_req) rd_addr = AW'($urandom);
        rd_req = 1'($urandom);
      end
      n++;
    end
    chk("drained_in_budget", (exp_q.size() == 0 && exp_all_done == 0), 1);
    exp_q.delete(); run_q.delete(); pend.delete();
    exp_all_done = 0;
    model_busy   = 1'b0;
    rd_req       = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin : main
    int n;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_tr_reset", tr_reset, 1);
    chk("rst_tr_start", tr_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_all_done", all_done, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_closed", res_closed, 0);
    chk("rst_res_timeout", res_timeout, 0);
    chk("rst_res_idx", res_idx, 0);
    chk("rst_rd_grant", rd_grant, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_seed_ready", seed_ready, 0);
    chk("rst_tr_addr_start", tr_addr_start, 0);
    reset = 1'b0;
    #1;
    chk("seed_ready_after_reset", seed_ready, 1);

    // Grant lags request by one cycle while idle.
    @(negedge clk);
    rd_addr = 19'h12345;
    rd_req  = 1'b1;
    #1;
    chk("grant_lag_low", rd_grant, 0);
    chk("idle_mem_addr", mem_addr, 19'h12345);
    @(negedge clk); #1;
    chk("grant_lag_high", rd_grant, 1);
    @(negedge clk);
    rd_req = 1'b0;
    #1;
    chk("grant_lag_hold", rd_grant, 1);
    @(negedge clk); #1;
    chk("grant_lag_release", rd_grant, 0);

    // Three closed contours with the readout continuously requesting.
    rd_req  = 1'b1;
    rd_hold = 1'b1;
    push_seed(19'd1000, 50, 3'd5, 1'b0);
    push_seed(19'd2000, 50, 3'd5, 1'b0);
    push_seed(19'd3000, 50, 3'd5, 1'b0);
    do_go();
    wait_drain(400, 1'b0);
    rd_hold = 1'b0;

    do_go();

    // Open contour, then a closed one; timeout, done/timeout tie, and just-before-limit.
    push_seed(19'd4321, 20, 3'd6, 1'b0);
    push_seed(19'd5555, 15, 3'd5, 1'b0);
    push_seed(19'd6000, 0, 3'd5, 1'b1);
    push_seed(19'd6100, 64, 3'd5, 1'b0);
    push_seed(19'd6200, 63, 3'd6, 1'b0);
    do_go();
    wait_drain(600, 1'b0);

    // Overfill: pushes nine and ten are dropped.
    for (int i = 0; i < 10; i++) push_seed(AW'(100 + 7 * i), 5 + i, 3'd5, 1'b0);
    do_go();
    wait_drain(600, 1'b0);

    // Push while busy joins the current batch; a second go is ignored.
    for (int i = 0; i < 4; i++) push_seed(AW'(20000 + i), 30, 3'd5, 1'b0);
    do_go();
    push_seed(19'd30000, 12, 3'd6, 1'b0);
    do_go();
    wait_drain(600, 1'b0);

    // Randomised batches with a random readout.
    for (int r = 0; r < 6; r++) begin
      n = int'($urandom_range(1, 8));
      for (int i = 0; i < n; i++)
        push_seed(AW'($urandom_range(0, 307199)), int'($urandom_range(2, 70)),
                  ($urandom_range(0, 1) != 0) ? 3'd5 : 3'd6, ($urandom_range(0, 7) == 0));
      do_go();
      wait_drain(1000, 1'b1);
    end

    // Reset in the middle of a run with five seeds still queued.
    for (int i = 0; i < 6; i++) push_seed(AW'(40000 + i), 0, 3'd5, 1'b1);
    do_go();
    n = 0;
    while (!tr_start && n < 20) begin @(negedge clk); n++; end
    chk("run_started", tr_start, 1);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk); #1;
    chk("midrun_rst_tr_reset", tr_reset, 1);
    chk("midrun_rst_tr_start", tr_start, 0);
    chk("midrun_rst_busy", busy, 0);
    chk("midrun_rst_res_valid", res_valid, 0);
    exp_q.delete(); run_q.delete(); pend.delete();
    exp_all_done = 0;
    model_busy   = 1'b0;
    reset        = 1'b0;
    repeat (3) @(negedge clk);
    do_go();
    wait_drain(20, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: got no finish, expected finish before %0d cycles", cyc);
    $fatal(1);
  end

endmodule
